// File: rtl/div_clk_mon.sv
// Divided-clock monitor: measures period and high time of a clk-synchronous
// divided clock, confirms the expected ratio (lock) and flags bad periods/timeouts.
module div_clk_mon #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned HIGH     = 2,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          lock,
  output logic          err,
  output logic [7:0]    err_cnt
);

  localparam int unsigned GW_MIN = 3;
  localparam int unsigned GW_REQ = int'($clog2(LOCK_CNT + 1));
  localparam int unsigned GW     = (GW_REQ > GW_MIN) ? GW_REQ : GW_MIN;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] DIV_V   = CW'(DIV);
  localparam logic [CW-1:0] HIGH_V  = CW'(HIGH);
  localparam logic [CW-1:0] TMO_V   = CW'(2 * DIV - 1);
  localparam logic [GW-1:0] LOCK_V  = GW'(LOCK_CNT);

  logic          div_d;
  logic [CW-1:0] per_cnt;
  logic [CW-1:0] hi_cnt;
  logic          hi_ok;
  logic [1:0]    state, state_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic          err_nxt;

  logic          rise_c, fall_c, tmo_c, good_c;
  logic [CW-1:0] per_p1_c;
  logic [GW-1:0] good_inc_c;

  // Edge detection and the combinational period check taken at each rise
  always_comb begin
    rise_c     = div_in & ~div_d;
    fall_c     = ~div_in & div_d;
    per_p1_c   = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CW'(1);
    good_c     = (per_p1_c == DIV_V) && hi_ok;
    tmo_c      = (state != S_IDLE) && (per_cnt == TMO_V) && !rise_c;
    good_inc_c = good_cnt + GW'(1);
  end

  // Next-state logic; a rise always takes priority over a timeout
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_nxt   = 1'b0;
    if (rise_c) begin
      if (state == S_IDLE) begin
        state_nxt = S_ACQ;
        good_nxt  = '0;
      end else if (!good_c) begin
        err_nxt   = 1'b1;
        good_nxt  = '0;
        state_nxt = S_ACQ;
      end else if (state == S_ACQ) begin
        good_nxt = good_inc_c;
        if (good_inc_c == LOCK_V) state_nxt = S_LOCKED;
      end else if (state != S_LOCKED) begin
        state_nxt = S_IDLE;
        good_nxt  = '0;
      end
    end else if (tmo_c) begin
      err_nxt   = 1'b1;
      good_nxt  = '0;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Measurement counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_d     <= 1'b0;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      hi_ok     <= 1'b0;
      period    <= '0;
      high_time <= '0;
      lock      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      div_d <= div_in;
      lock  <= (state_nxt == S_LOCKED);
      err   <= err_nxt;
      if (err_nxt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      if (rise_c) begin
        per_cnt <= '0;
        period  <= per_p1_c;
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + CW'(1);
      end

      if (rise_c) hi_cnt <= CW'(1);
      else if (div_in && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CW'(1);

      if (fall_c) high_time <= hi_cnt;
      // A timeout invalidates any high time captured in the same cycle
      if (tmo_c) hi_ok <= 1'b0;
      else if (fall_c) hi_ok <= (hi_cnt == HIGH_V);
    end
  end

endmodule

// File: tb/tb_div_clk_mon.sv
// Randomised and directed bench for div_clk_mon, checked every cycle against a
// timestamp-based model of the measurement and lock rules.
module tb_div_clk_mon;

  localparam int DIV      = 4;
  localparam int HIGH     = 2;
  localparam int LOCK_CNT = 4;
  localparam int CW       = 8;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          div_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          lock;
  logic          err;
  logic [7:0]    err_cnt;

  int n_cmp  = 0;
  int n_bad  = 0;
  bit cmp_en = 1'b0;

  div_clk_mon #(.DIV(DIV), .HIGH(HIGH), .LOCK_CNT(LOCK_CNT), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_in    (div_in),
    .period    (period),
    .high_time (high_time),
    .lock      (lock),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: times in cycles since reset release; mode 0=idle 1=acquiring 2=locked
  int m_t, m_last_rise, m_len, m_mode, m_good, m_ecnt, m_per, m_high;
  bit m_prev, m_hi_ok, m_err, m_r, m_f;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t = 0; m_last_rise = -1; m_mode = 0; m_good = 0; m_ecnt = 0;
      m_per = 0; m_high = 0; m_prev = 0; m_hi_ok = 0; m_err = 0;
    end else begin
      m_r   = div_in && !m_prev;
      m_f   = !div_in && m_prev;
      m_err = 0;
      m_len = m_t - m_last_rise;
      if (m_len > 255) m_len = 255;
      if (m_r) begin
        m_per = m_len;
        if (m_mode == 0) begin
          m_mode = 1; m_good = 0;
        end else if (m_len == DIV && m_hi_ok) begin
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LOCK_CNT) m_mode = 2;
          end
        end else begin
          m_err = 1; m_good = 0; m_mode = 1;
        end
        m_last_rise = m_t;
      end
      if (m_f) begin
        m_high  = m_len;
        m_hi_ok = (m_len == HIGH);
      end
      if (!m_r && m_mode != 0 && (m_t - m_last_rise) == 2 * DIV) begin
        m_err = 1; m_good = 0; m_hi_ok = 0; m_mode = 0;
      end
      if (m_err && m_ecnt < 255) m_ecnt++;
      m_prev = div_in;
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("period",    int'(period),    m_per);
      chk("high_time", int'(high_time), m_high);
      chk("lock",      int'(lock),      (m_mode == 2) ? 1 : 0);
      chk("err",       int'(err),       int'(m_err));
      chk("err_cnt",   int'(err_cnt),   m_ecnt);
    end
  end

  task automatic cyc(input bit b);
    div_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic per(input int p, input int h);
    for (int i = 0; i < p; i++) cyc(i < h);
  endtask

  // Assert reset asynchronously mid-cycle, check immediate clear, then release
  task automatic reset_async(input string tag);
    #2 rst = 1'b0;
    div_in = 1'b0;
    #1;
    chk({tag, "_rst_period"},  int'(period),    0);
    chk({tag, "_rst_high"},    int'(high_time), 0);
    chk({tag, "_rst_lock"},    int'(lock),      0);
    chk({tag, "_rst_err"},     int'(err),       0);
    chk({tag, "_rst_err_cnt"}, int'(err_cnt),   0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
  endtask

  // From idle with div_in low: lock must appear exactly 17 cycles after the first rise
  task automatic ideal_lock(input string tag);
    for (int k = 0; k < LOCK_CNT; k++) per(DIV, HIGH);
    chk({tag, "_lock_t0+16"}, int'(lock), 0);
    cyc(1'b1);
    chk({tag, "_lock_t0+17"}, int'(lock), 1);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    chk({tag, "_period"}, int'(period),    4);
    chk({tag, "_high"},   int'(high_time), 2);
  endtask

  initial begin
    int e0, epos, epulses, kind, p, h;
    @(posedge clk);
    #1;
    reset_async("init");
    cmp_en = 1'b1;

    // Ideal divide-by-4
    ideal_lock("ideal");
    for (int k = 0; k < 3; k++) per(DIV, HIGH);
    chk("ideal_err_cnt", int'(err_cnt), 0);

    // Glitch period of 5, then relock after 4 good periods
    per(5, 2);
    cyc(1'b1);
    chk("glitch_err",     int'(err),     1);
    chk("glitch_lock",    int'(lock),    0);
    chk("glitch_err_cnt", int'(err_cnt), 1);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    for (int k = 0; k < 3; k++) per(DIV, HIGH);
    chk("relock_t+16", int'(lock), 0);
    cyc(1'b1);
    chk("relock_t+17", int'(lock), 1);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);

    // Stuck low after lock: one timeout error visible 9 cycles after the last rise
    e0 = int'(err_cnt); epos = -1; epulses = 0;
    for (int j = 1; j <= 14; j++) begin
      cyc(j <= 2);
      if (err) begin epos = j; epulses++; end
    end
    chk("stuck_err_pos",    epos,           9);
    chk("stuck_err_pulses", epulses,        1);
    chk("stuck_lock",       int'(lock),     0);
    chk("stuck_err_cnt",    int'(err_cnt),  e0 + 1);
    cyc(1'b1);
    chk("stuck_next_rise_unchecked", int'(err), 0);
    cyc(1'b1); cyc(1'b0); cyc(1'b0);

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 6) begin
        per(DIV, HIGH);
      end else if (kind == 7) begin
        p = int'($urandom_range(2, 10));
        h = int'($urandom_range(1, p - 1));
        per(p, h);
      end else if (kind == 8) begin
        per(DIV, int'($urandom_range(1, DIV - 1)));
      end else begin
        per(int'($urandom_range(9, 14)), HIGH);
      end
    end

    // Reset while locked, then relock
    for (int k = 0; k < 7; k++) per(DIV, HIGH);
    chk("pre_reset_lock", int'(lock), 1);
    reset_async("mid");
    ideal_lock("after_reset");

    // Wrong duty: every checked rise errors, counter saturates
    reset_async("duty");
    for (int k = 0; k < 300; k++) per(DIV, 3);
    chk("duty_high",    int'(high_time), 3);
    chk("duty_err_cnt", int'(err_cnt),   255);
    chk("duty_lock",    int'(lock),      0);
    per(DIV, 3);
    cyc(1'b1);
    chk("duty_err_sat_pulse", int'(err),     1);
    chk("duty_err_cnt_sat",   int'(err_cnt), 255);
    cyc(1'b1); cyc(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
